seq_serializer: RTL and testbench
=================================

# seq_serializer

Parallel-to-serial feeder placed directly upstream of the serial pattern detector. It accepts WORD_W-bit words over a valid/ready handshake and buffers them in a small FIFO. It emits them one bit per clock on a single serial line that drives the detector's serial `in` input. Words leave back-to-back with no idle gap, so patterns that straddle a word boundary are still seen by the detector.

## Interface
- WORD_W, 8: bits per word; at least 2.
- DEPTH, 4: FIFO depth in words; a power of 2, at least 2.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WORD_W  word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word; a transfer occurs when in_valid && in_ready at the rising edge.
- ser_out  output  1  serial bit to the detector `in` input; 0 when idle.
- ser_active  output  1  ser_out carries a data bit this cycle.
- word_start  output  1  one-cycle pulse coinciding with the first bit of each word.
- fifo_level  output  $clog2(DEPTH)+1  number of words buffered, excluding the word currently shifting.

## Operation
- The FIFO uses write/read pointers plus a level counter, all registered.
- The shift path has two states:
  - IDLE: ser_out=0, ser_active=0. If the FIFO is non-empty at the edge, pop the head word into the shift register, set bit_cnt=WORD_W-1, and go to SHIFT.
  - SHIFT: ser_out is the current bit and ser_active=1. At each edge, shift by one and decrement bit_cnt.
  - When bit_cnt=0 in SHIFT and the FIFO is non-empty, pop and load the next word at that same edge and stay in SHIFT. This keeps the stream gapless.
  - When bit_cnt=0 in SHIFT and the FIFO is empty, go to IDLE.
- Bit order is MSB first unless SER_LSB_FIRST_EN is defined.
- in_ready = !rst && (fifo_level != DEPTH). It depends only on registered level. A pop in the same cycle does not free space for a push; a full FIFO accepts no word in that cycle.
- A simultaneous push and pop on a non-full FIFO leaves fifo_level unchanged. Pointers wrap modulo DEPTH.
- in_data is ignored when in_valid=0 or in_ready=0, and the FIFO is not modified.
- word_start=1 in exactly the cycle where bit_cnt=WORD_W-1 and state is SHIFT.

## Timing
- Reset sets state=IDLE, pointers=0, fifo_level=0, bit_cnt=0, shift register=0, ser_out=0, ser_active=0, word_start=0, in_ready=0.
- in_ready rises in the first cycle after rst deasserts.
- Latency: a word accepted into an empty FIFO while IDLE at edge k is popped at edge k+1. Its first bit appears on ser_out in cycle k+1..k+2, and its last bit in cycle k+WORD_W..k+WORD_W+1.
- ser_out, ser_active and word_start are all registered; there is no combinational path from in_* to the serial outputs.
- Reset asserted mid-word aborts the word and discards the FIFO contents. ser_out is 0 from the cycle after the reset edge.
- Throughput is one word per WORD_W cycles. Sustained input faster than that fills the FIFO and backpressures through in_ready.

## Configuration
- SER_LSB_FIRST_EN:
  - Defined: bit 0 of each word is sent first and the shift register shifts right.
  - Undefined (default): bit WORD_W-1 is sent first and the register shifts left.
- No other behaviour changes.

## Structure
- Shared package seq_pkg holds:
  - the state typedef (IDLE, SHIFT, 1-bit encoding);
  - default WORD_W/DEPTH constants, shared with the detector's testbench.
- Sub-module seq_fifo: synchronous FIFO with push/pop/level/full/empty.
- The top level instantiates seq_fifo and contains only the shift FSM and bit counter.

## Test plan
- Single word 8'hDB (MSB first) into an idle block -> ser_out = 1,1,0,1,1,0,1,1 on 8 consecutive cycles; ser_active high exactly 8 cycles; word_start high on the first; then ser_out=0.
- Two words 8'h03 then 8'h60 pushed back-to-back -> 16 contiguous active bits with no gap. Driven into the detector, the boundary bits ...11|011... produce exactly one detect pulse.
- Push 6 words on consecutive cycles with DEPTH=4 -> in_ready drops to 0 when fifo_level=4. No word is lost or duplicated, and all 6 are serialized in order over 48 contiguous cycles.
- Push while full with an in-flight pop in the same cycle -> that push is not accepted and fifo_level goes 4->3.
- Assert rst at bit 3 of a word with 2 words queued -> next cycle ser_out=0, ser_active=0, fifo_level=0; in_ready=1 one cycle after rst deasserts.
- Build with SER_LSB_FIRST_EN, send 8'hDB -> ser_out = 1,1,0,1,1,0,1,1 (bit 0 first).

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state type and default sizes for the serializer and detector benches
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - synchronous word FIFO with registered pointers and level counter
module seq_fifo
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WORD_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - gapless word-to-bit serializer feeding the pattern detector
// Define SER_LSB_FIRST_EN to send bit 0 first; default is MSB first.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WORD_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       ser_out,
    output logic                       ser_active,
    output logic                       word_start,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);

    ser_state_t        state, state_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n;
    logic              pop;
    logic              push;
    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_n;

    // Readiness comes only from the registered level, so a same-cycle pop never frees a slot.
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;

    seq_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
            word_start <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            ser_out    <= (state_n == SHIFT) ? bit_n : 1'b0;
            ser_active <= (state_n == SHIFT);
            word_start <= (state_n == SHIFT) && (bit_cnt_n == CNT_LAST);
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_n   = head;
                    bit_cnt_n = CNT_LAST;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
                    // Reload on the last bit keeps consecutive words back-to-back.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_n   = head;
                        bit_cnt_n = CNT_LAST;
                    end else begin
                        state_n   = IDLE;
                    end
                end else begin
`ifdef SER_LSB_FIRST_EN
                    shreg_n   = shreg >> 1;
`else
                    shreg_n   = shreg << 1;
`endif
                    bit_cnt_n = bit_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef SER_LSB_FIRST_EN
        bit_n = shreg_n[0];
`else
        bit_n = shreg_n[WORD_W-1];
`endif
    end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - scoreboard bench for seq_serializer (honours SER_LSB_FIRST_EN)
module tb_seq_serializer;
    import seq_pkg::*;

    localparam int W  = DEF_WORD_W;
    localparam int D  = DEF_DEPTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [W-1:0]           in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   ser_out;
    logic                   ser_active;
    logic                   word_start;
    logic [$clog2(D):0]     fifo_level;

    typedef struct {
        logic b;
        logic first;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_len = 0;
    int last_run = 0;
    int bit_idx = 0;
    int acc_cyc = 0;
    int full_pop_events = 0;
    logic lat_armed = 1'b0;
    logic acc;
    logic prev_valid;
    logic [$clog2(D):0] prev_level;
    logic [W-1:0] cap;

    seq_serializer #(.WORD_W(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .word_start (word_start),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic enqueue(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_t e;
`ifdef SER_LSB_FIRST_EN
            e.b = w[i];
`else
            e.b = w[W-1-i];
`endif
            e.first = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        #1;
        acc        = in_valid && in_ready;
        prev_level = fifo_level;
        prev_valid = in_valid;
        if (acc) enqueue(in_data);
        @(posedge clk);
        #1;
        cyc++;
        if (acc) acc_cyc = cyc;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!rst && fifo_level != D)});
        if (prev_level == D && prev_valid && fifo_level != D && !rst) begin
            full_pop_events++;
            check("full_pop_level", fifo_level, 3);
        end
        if (ser_active) begin
            run_len++;
            cap = {cap[W-2:0], ser_out};
            bit_idx = word_start ? 0 : bit_idx + 1;
            if (lat_armed && word_start) begin
                check("latency", cyc - acc_cyc, 1);
                lat_armed = 1'b0;
            end
            if (sb.size() == 0) begin
                check("extra_bit", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ser_out", {31'd0, ser_out}, {31'd0, e.b});
                check("word_start", {31'd0, word_start}, {31'd0, e.first});
            end
        end else begin
            check("idle_out", {30'd0, ser_out, word_start}, 0);
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc && n < 100);
        if (!acc) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || ser_active || run_len != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        cap = '0;
        step();
        step();
        check("rst_ready", {31'd0, in_ready}, 0);
        check("rst_active", {31'd0, ser_active}, 0);
        check("rst_level", fifo_level, 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", {31'd0, in_ready}, 1);

        // single word, latency and bit pattern (DB is a bit palindrome)
        cap = '0;
        lat_armed = 1'b1;
        push_word(8'hDB);
        drain();
        check("single_cap", cap, 8'hDB);
        check("single_run", last_run, 8);
        check("latency_seen", {31'd0, lat_armed}, 0);

        // two words back-to-back with no gap
        push_word(8'h03);
        push_word(8'h60);
        drain();
        check("two_run", last_run, 16);

        // six words into a depth-4 FIFO
        for (int i = 0; i < 6; i++) push_word(W'(8'hA1 + i * 8'h13));
        drain();
        check("six_run", last_run, 48);
        check("full_pop_seen", {31'd0, full_pop_events > 0}, 1);

        // reset in the middle of a word with two queued
        push_word(8'hF0);
        push_word(8'h5A);
        push_word(8'hC3);
        for (int n = 0; n < 50 && !(ser_active && bit_idx == 3); n++) step();
        check("mid_bit3", {31'd0, (ser_active && bit_idx == 3)}, 1);
        check("level_before_rst", fifo_level, 2);
        rst = 1'b1;
        sb.delete();
        step();
        run_len = 0;
        check("rst_mid_out", {31'd0, ser_out}, 0);
        check("rst_mid_active", {31'd0, ser_active}, 0);
        check("rst_mid_level", fifo_level, 0);
        rst = 1'b0;
        step();
        check("rst_mid_ready", {31'd0, in_ready}, 1);
        drain();

        // stream still works after the abort
        cap = '0;
        push_word(8'hDB);
        drain();
        check("post_rst_cap", cap, 8'hDB);
        check("post_rst_run", last_run, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
